// File: rtl/min_os_pkg.sv
// Shared constants and state encodings for the MinOS UART link (host and device ends).
// Optional build macro used by min_os_host: MIN_OS_HOST_TIMEOUT_EN.
package min_os_pkg;

    localparam logic [7:0] CMD_SWITCHES = 8'h01;
    localparam logic [7:0] CMD_LEDS     = 8'h02;
    localparam logic [7:0] CMD_DISPLAY  = 8'h03;

    localparam int DEFAULT_DISPLAY_BYTES = 64;
    localparam int TX_FRAME_BITS         = 20;

    typedef enum logic [1:0] {P_IDLE, P_LEDS, P_DISP} parse_state_t;
    typedef enum logic       {T_IDLE, T_SEND}         tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    // Two 8N1 characters, shifted out LSB first: start, CMD_SWITCHES, stop, start, sw, stop.
    function automatic logic [TX_FRAME_BITS-1:0] tx_frame(input logic [7:0] sw);
        return {1'b1, sw, 1'b0, 1'b1, CMD_SWITCHES, 1'b0};
    endfunction

endpackage

// File: rtl/min_os_uart_rx.sv
// 8N1 UART byte receiver with a 2-flop synchronizer; strobe or stop_err fires
// one cycle after the stop-bit centre sample.
module min_os_uart_rx
    import min_os_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx,
    output logic [7:0] data,
    output logic       strobe,
    output logic       stop_err
);

    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    rx_state_t       r_state, r_next;
    logic            rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic            half_hit, full_hit;

    assign half_hit = (cnt == CW'(HALF - 1));
    assign full_hit = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (rx_prev && !rx_sync) r_next = R_START;
            // A start bit that is high again at mid-bit was a glitch.
            R_START: if (half_hit) r_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (full_hit && bit_idx == 3'd7) r_next = R_STOP;
            R_STOP:  if (full_hit) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            bit_idx  <= '0;
            data     <= '0;
            strobe   <= 1'b0;
            stop_err <= 1'b0;
        end else begin
            strobe   <= (r_state == R_STOP) && full_hit && rx_sync;
            stop_err <= (r_state == R_STOP) && full_hit && !rx_sync;
            if (r_state == R_IDLE || (r_state == R_START && half_hit) || full_hit)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (r_state == R_START) begin
                bit_idx <= '0;
            end else if (r_state == R_DATA && full_hit) begin
                data    <= {rx_sync, data[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/min_os_host.sv
// Host-end peer of the MinOS UART link: sends switch frames, parses LED/display frames.
// Optional inter-byte timeout enabled by defining MIN_OS_HOST_TIMEOUT_EN.
module min_os_host
    import min_os_pkg::*;
#(
    parameter int CLK_HZ        = 100000000,
    parameter int BAUD          = 115200,
    parameter int DISPLAY_BYTES = DEFAULT_DISPLAY_BYTES,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       rx,
    output logic                       tx,
    input  logic [7:0]                 switches,
    output logic [7:0]                 leds,
    output logic [8*DISPLAY_BYTES-1:0] display,
    output logic                       leds_valid,
    output logic                       display_valid,
    output logic                       frame_error,
    output logic                       tx_busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W        = $clog2(DISPLAY_BYTES);

    logic [7:0] rx_data;
    logic       rx_strobe, rx_err, timeout_hit;

    min_os_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .CLK      (CLK),
        .RST      (RST),
        .rx       (rx),
        .data     (rx_data),
        .strobe   (rx_strobe),
        .stop_err (rx_err)
    );

    // ---------------- parser ----------------
    parse_state_t                p_state, p_next;
    logic [IDX_W-1:0]            idx;
    logic [8*(DISPLAY_BYTES-1)-1:0] shadow;
    logic                        leds_we, disp_wr, disp_done;

`ifdef MIN_OS_HOST_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
    logic [31:0] to_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                               to_cnt <= '0;
        else if (p_state == P_IDLE || rx_strobe) to_cnt <= '0;
        else                                   to_cnt <= to_cnt + 32'd1;
    end

    assign timeout_hit = (p_state != P_IDLE) && !rx_strobe && (to_cnt == 32'(TO_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) p_state <= P_IDLE;
        else     p_state <= p_next;
    end

    always_comb begin
        p_next    = p_state;
        leds_we   = 1'b0;
        disp_wr   = 1'b0;
        disp_done = 1'b0;
        if (rx_err || timeout_hit) begin
            p_next = P_IDLE;
        end else if (rx_strobe) begin
            case (p_state)
                P_IDLE: begin
                    if (rx_data == CMD_LEDS)         p_next = P_LEDS;
                    else if (rx_data == CMD_DISPLAY) p_next = P_DISP;
                end
                P_LEDS: begin
                    leds_we = 1'b1;
                    p_next  = P_IDLE;
                end
                P_DISP: begin
                    if (idx == IDX_W'(DISPLAY_BYTES - 1)) begin
                        disp_done = 1'b1;
                        p_next    = P_IDLE;
                    end else begin
                        disp_wr = 1'b1;
                    end
                end
                default: p_next = P_IDLE;
            endcase
        end
    end

    // The final display byte bypasses the shadow so the copy lands in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            leds          <= '0;
            display       <= '0;
            shadow        <= '0;
            idx           <= '0;
            leds_valid    <= 1'b0;
            display_valid <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            leds_valid    <= leds_we;
            display_valid <= disp_done;
            frame_error   <= rx_err || timeout_hit;
            if (leds_we) leds <= rx_data;
            if (p_state != P_DISP) idx <= '0;
            else if (disp_wr)      idx <= idx + IDX_W'(1);
            if (disp_wr) begin
                for (int i = 0; i < DISPLAY_BYTES - 1; i++)
                    if (idx == IDX_W'(i)) shadow[i*8 +: 8] <= rx_data;
            end
            if (disp_done) display <= {rx_data, shadow};
        end
    end

    // ---------------- switch transmitter ----------------
    tx_state_t                 tx_state, tx_next;
    logic                      dirty, tx_start;
    logic [7:0]                sent_val;
    logic [TX_FRAME_BITS-1:0]  tx_shreg;
    logic [CW-1:0]             tx_clk;
    logic [4:0]                tx_bit;
    logic                      tx_bit_end;

    assign tx_bit_end = (tx_clk == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) tx_state <= T_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next  = tx_state;
        tx_start = 1'b0;
        case (tx_state)
            T_IDLE: if (dirty) begin
                tx_start = 1'b1;
                tx_next  = T_SEND;
            end
            T_SEND: if (tx_bit_end && tx_bit == 5'(TX_FRAME_BITS - 1)) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    // dirty starts set so the first frame after reset reports the current switches.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dirty    <= 1'b1;
            sent_val <= '0;
            tx_shreg <= '1;
            tx_clk   <= '0;
            tx_bit   <= '0;
        end else if (tx_start) begin
            dirty    <= 1'b0;
            sent_val <= switches;
            tx_shreg <= tx_frame(switches);
            tx_clk   <= '0;
            tx_bit   <= '0;
        end else begin
            if (switches != sent_val) dirty <= 1'b1;
            if (tx_state == T_SEND) begin
                if (tx_bit_end) begin
                    tx_clk   <= '0;
                    tx_bit   <= tx_bit + 5'd1;
                    tx_shreg <= {1'b1, tx_shreg[TX_FRAME_BITS-1:1]};
                end else begin
                    tx_clk <= tx_clk + CW'(1);
                end
            end
        end
    end

    assign tx      = (tx_state == T_SEND) ? tx_shreg[0] : 1'b1;
    assign tx_busy = (tx_state == T_SEND);

endmodule

// File: tb/tb_min_os_host.sv
// Directed bench for min_os_host at 16 clocks per bit; also covers MIN_OS_HOST_TIMEOUT_EN when defined.
module tb_min_os_host;

    localparam int CLK_HZ = 1600;
    localparam int BAUD   = 100;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int DB     = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          rx  = 1'b1;
    logic [7:0]    switches = 8'h00;
    logic          tx, leds_valid, display_valid, frame_error, tx_busy;
    logic [7:0]    leds;
    logic [8*DB-1:0] display;

    int errors = 0;
    int checks = 0;
    int n_leds = 0;
    int n_disp = 0;
    int n_ferr = 0;

    min_os_host #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DISPLAY_BYTES(DB), .TIMEOUT_BYTES(4)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .rx            (rx),
        .tx            (tx),
        .switches      (switches),
        .leds          (leds),
        .display       (display),
        .leds_valid    (leds_valid),
        .display_valid (display_valid),
        .frame_error   (frame_error),
        .tx_busy       (tx_busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (leds_valid)    n_leds++;
        if (display_valid) n_disp++;
        if (frame_error)   n_ferr++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Device-side 8N1 character, LSB first; called on a negedge.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge CLK);
        end
        rx = stop;
        repeat (CPB) @(negedge CLK);
        rx = 1'b1;
    endtask

    // Waits up to budget cycles for tx_busy, then samples tx at every bit centre.
    task automatic capture_frame(input int budget, output logic seen, output logic [7:0] b0,
                                 output logic [7:0] b1, output logic framing_ok, output int busy_cycles);
        logic [19:0] bits;
        int waited;
        int k;
        bits = '1;
        waited = 0;
        while (!tx_busy && waited < budget) begin
            @(negedge CLK);
            waited++;
        end
        seen = tx_busy;
        k = 0;
        while (tx_busy && k < 30 * CPB) begin
            if (k % CPB == CPB / 2 && k / CPB < 20) bits[k / CPB] = tx;
            k++;
            @(negedge CLK);
        end
        busy_cycles = k;
        b0 = bits[8:1];
        b1 = bits[18:11];
        framing_ok = (bits[0] == 1'b0) && (bits[9] == 1'b1) && (bits[10] == 1'b0) && (bits[19] == 1'b1);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        switches = 8'hA5;
        repeat (3) @(negedge CLK);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds got %h want 00", leds); end
        checks++; if (display !== '0) begin errors++; $display("FAIL reset_display got %h want 0", display); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b want 0", tx_busy); end
        checks++;
        if ({leds_valid, display_valid, frame_error} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b want 000", {leds_valid, display_valid, frame_error});
        end
        RST = 1'b0;
    endtask

    task automatic test_first_tx_frame;
        logic seen, fok;
        logic [7:0] b0, b1;
        int bc;
        capture_frame(10, seen, b0, b1, fok, bc);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL tx0_started got %b want 1", seen); end
        checks++; if (b0 !== 8'h01) begin errors++; $display("FAIL tx0_cmd got %h want 01", b0); end
        checks++; if (b1 !== 8'hA5) begin errors++; $display("FAIL tx0_value got %h want a5", b1); end
        checks++; if (fok !== 1'b1) begin errors++; $display("FAIL tx0_framing got %b want 1", fok); end
        checks++; if (bc != 20 * CPB) begin errors++; $display("FAIL tx0_busy_len got %0d want %0d", bc, 20 * CPB); end
    endtask

    task automatic test_leds;
        int l0, d0;
        l0 = n_leds; d0 = n_disp;
        send_byte(8'h7E, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h3C, 1'b1);
        repeat (4) @(negedge CLK);
        checks++; if (leds !== 8'h3C) begin errors++; $display("FAIL leds_value got %h want 3c", leds); end
        checks++; if (n_leds - l0 != 1) begin errors++; $display("FAIL leds_pulses got %0d want 1", n_leds - l0); end
        checks++; if (n_disp - d0 != 0) begin errors++; $display("FAIL leds_no_disp got %0d want 0", n_disp - d0); end
    endtask

    task automatic test_display;
        logic [8*DB-1:0] exp_disp;
        logic [7:0] lo_b, hi_b;
        int d0, f0;
        d0 = n_disp; f0 = n_ferr;
        for (int i = 0; i < DB; i++) exp_disp[i*8 +: 8] = 8'(i + 1);
        send_byte(8'h03, 1'b1);
        for (int i = 0; i < DB - 1; i++) send_byte(8'(i + 1), 1'b1);
        repeat (4) @(negedge CLK);
        checks++; if (display !== '0) begin errors++; $display("FAIL disp_partial got %h want 0", display); end
        checks++; if (n_disp != d0) begin errors++; $display("FAIL disp_early_pulse got %0d want 0", n_disp - d0); end
        send_byte(8'(DB), 1'b1);
        repeat (4) @(negedge CLK);
        lo_b = display[7:0];
        hi_b = display[8*DB-1 -: 8];
        checks++; if (n_disp - d0 != 1) begin errors++; $display("FAIL disp_pulses got %0d want 1", n_disp - d0); end
        checks++; if (lo_b !== 8'h01) begin errors++; $display("FAIL disp_byte0 got %h want 01", lo_b); end
        checks++; if (hi_b !== 8'h40) begin errors++; $display("FAIL disp_byte63 got %h want 40", hi_b); end
        checks++; if (display !== exp_disp) begin errors++; $display("FAIL disp_full got %h want %h", display, exp_disp); end
        checks++; if (n_ferr != f0) begin errors++; $display("FAIL disp_no_err got %0d want 0", n_ferr - f0); end
    endtask

    task automatic test_frame_error;
        logic [8*DB-1:0] prev;
        int d0, f0, l0;
        prev = display; d0 = n_disp; f0 = n_ferr; l0 = n_leds;
        send_byte(8'h03, 1'b1);
        for (int i = 0; i < 10; i++) send_byte(8'(8'hC0 + i), 1'b1);
        send_byte(8'hCA, 1'b0);
        repeat (2 * CPB) @(negedge CLK);
        checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", n_ferr - f0); end
        checks++; if (display !== prev) begin errors++; $display("FAIL ferr_display got %h want %h", display, prev); end
        send_byte(8'h02, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (4) @(negedge CLK);
        checks++; if (leds !== 8'h55) begin errors++; $display("FAIL ferr_recover_leds got %h want 55", leds); end
        checks++; if (n_leds - l0 != 1) begin errors++; $display("FAIL ferr_recover_pulse got %0d want 1", n_leds - l0); end
        checks++; if (n_disp != d0) begin errors++; $display("FAIL ferr_no_disp got %0d want 0", n_disp - d0); end
    endtask

    task automatic test_switch_update;
        logic s1, s2, s3, f1, f2, f3;
        logic [7:0] a1, v1, a2, v2, a3, v3;
        int c1, c2, c3;
        switches = 8'h00;
        fork
            begin
                capture_frame(10, s1, a1, v1, f1, c1);
                capture_frame(10, s2, a2, v2, f2, c2);
            end
            begin
                repeat (3 * CPB) @(negedge CLK);
                switches = 8'h11;
                repeat (7 * CPB) @(negedge CLK);
                switches = 8'h22;
            end
        join
        checks++; if (s1 !== 1'b1 || v1 !== 8'h00) begin errors++; $display("FAIL sw_frame1 got seen=%b val=%h want seen=1 val=00", s1, v1); end
        checks++; if (s2 !== 1'b1 || a2 !== 8'h01 || v2 !== 8'h22) begin errors++; $display("FAIL sw_frame2 got seen=%b cmd=%h val=%h want seen=1 cmd=01 val=22", s2, a2, v2); end
        checks++; if (f2 !== 1'b1) begin errors++; $display("FAIL sw_frame2_framing got %b want 1", f2); end
        capture_frame(25 * CPB, s3, a3, v3, f3, c3);
        checks++; if (s3 !== 1'b0) begin errors++; $display("FAIL sw_no_extra_frame got seen=%b val=%h want seen=0", s3, v3); end
    endtask

`ifdef MIN_OS_HOST_TIMEOUT_EN
    task automatic test_timeout;
        int f0, l0, d0;
        f0 = n_ferr; l0 = n_leds; d0 = n_disp;
        send_byte(8'h03, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h80 ^ i), 1'b1);
        repeat (5 * 10 * CPB) @(negedge CLK);
        checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL timeout_pulses got %0d want 1", n_ferr - f0); end
        send_byte(8'h02, 1'b1);
        send_byte(8'h07, 1'b1);
        repeat (4) @(negedge CLK);
        checks++; if (leds !== 8'h07) begin errors++; $display("FAIL timeout_recover_leds got %h want 07", leds); end
        checks++; if (n_leds - l0 != 1) begin errors++; $display("FAIL timeout_recover_pulse got %0d want 1", n_leds - l0); end
        checks++; if (n_disp != d0) begin errors++; $display("FAIL timeout_no_disp got %0d want 0", n_disp - d0); end
    endtask
`else
    task automatic test_no_timeout;
        logic [8*DB-1:0] exp_disp;
        int f0, d0;
        f0 = n_ferr; d0 = n_disp;
        for (int i = 0; i < DB; i++) exp_disp[i*8 +: 8] = 8'(8'h80 ^ i);
        send_byte(8'h03, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(exp_disp[i*8 +: 8], 1'b1);
        repeat (5 * 10 * CPB) @(negedge CLK);
        checks++; if (n_ferr != f0) begin errors++; $display("FAIL notimeout_err got %0d want 0", n_ferr - f0); end
        for (int i = 5; i < DB; i++) send_byte(exp_disp[i*8 +: 8], 1'b1);
        repeat (4) @(negedge CLK);
        checks++; if (n_disp - d0 != 1) begin errors++; $display("FAIL notimeout_pulses got %0d want 1", n_disp - d0); end
        checks++; if (display !== exp_disp) begin errors++; $display("FAIL notimeout_display got %h want %h", display, exp_disp); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_tx_frame();
        test_leds();
        test_display();
        test_frame_error();
        test_switch_update();
`ifdef MIN_OS_HOST_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/min_os_host.md
Name: min_os_host

Overview:
- Host-end peer of the MinOS UART link: plays the role a PC plays opposite a board running MinOS.
- Transmits switch-update frames whenever the local switch byte changes.
- Receives LED and display frames and presents them as registered outputs.
- Used on a second board for board-to-board loopback and as a synthesizable protocol checker for MinOS images.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 868 at defaults).
- DISPLAY_BYTES, 64, payload length of a display frame.
- TIMEOUT_BYTES, 4, inter-byte gap limit in byte-times. Used only with the optional feature.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- rx  in  1  UART line from the device's TX, asynchronous.
- tx  out  1  UART line to the device's RX; idles high.
- switches  in  8  switch byte to mirror to the device.
- leds  out  8  last LED byte received.
- display  out  8*DISPLAY_BYTES  last complete display frame; byte i at [i*8 +: 8].
- leds_valid  out  1  one-cycle pulse when leds updates.
- display_valid  out  1  one-cycle pulse when display updates.
- frame_error  out  1  one-cycle pulse on a bad stop bit or an aborted frame.
- tx_busy  out  1  high while a switch frame is being sent.

Behaviour:
- Protocol:
  - UART 8N1, LSB first.
  - Host->device: 0x01, sw. Two bytes.
  - Device->host: 0x02, led. Two bytes.
  - Device->host: 0x03, then DISPLAY_BYTES bytes, byte 0 first.
  - Any other command byte is ignored silently.
- Reset values: tx=1; leds=0; display=0; all pulses=0; tx_busy=0; all FSMs idle.
- Reset may assert at any time and aborts any partial frame with no output update.
- RX byte receiver:
  - 2-flop synchronizer on rx.
  - Falling edge in idle starts reception; start bit re-checked at CLKS_PER_BIT/2 and treated as a glitch if high.
  - Data bits sampled at bit centres.
  - Stop bit sampled at its centre: if 0, the byte is dropped and frame_error pulses.
  - Otherwise a byte strobe fires 1 cycle after the stop-bit sample.
- Parser FSM, states P_IDLE, P_LEDS, P_DISP:
  - P_IDLE: 0x02 -> P_LEDS; 0x03 -> P_DISP with idx=0; other bytes stay in P_IDLE.
  - P_LEDS: the byte is written to leds, leds_valid pulses in the same cycle, -> P_IDLE.
  - P_DISP: the byte goes into the shadow buffer at idx, idx increments. At idx=DISPLAY_BYTES-1 the shadow is copied to display, display_valid pulses, -> P_IDLE.
  - display never shows a partial frame.
  - A receive framing error in P_LEDS/P_DISP -> P_IDLE, shadow discarded, display unchanged; frame_error pulses once.
- TX:
  - dirty flag set at reset and whenever switches != last_sent.
  - In T_IDLE with dirty set: latch switches into sent_val, clear dirty, tx_busy=1, send 0x01 then sent_val, then T_IDLE.
  - Frame length is 20 bit-times, back-to-back with no inter-byte gap.
  - Switch changes during a frame do not alter it; they set dirty, so exactly one follow-up frame carries the latest value.
  - tx_busy falls in the cycle after the second stop bit completes.
- RX and TX are fully independent; simultaneous activity is allowed.

Optional Feature:
- Macro: MIN_OS_HOST_TIMEOUT_EN.
- Defined: a counter runs while the parser is in P_LEDS/P_DISP. If no byte strobe arrives within TIMEOUT_BYTES*10*CLKS_PER_BIT cycles of the previous one, the parser returns to P_IDLE, discards the shadow and pulses frame_error.
- Undefined: no counter; a partial frame waits indefinitely.

Decomposition:
- Package min_os_pkg:
  - command constants CMD_SWITCHES=8'h01, CMD_LEDS=8'h02, CMD_DISPLAY=8'h03;
  - parser and TX state encodings;
  - default DISPLAY_BYTES.
- Sub-module min_os_uart_rx: byte receiver with the synchronizer, outputs data[7:0], strobe and stop_err. It is reusable by min_os itself.
- The TX serializer stays inline.

Test Plan:
- Release reset with switches=8'hA5 -> tx carries 0x01 then 0xA5, 8N1 LSB-first, 868 cycles/bit; tx_busy high for exactly 20 bit-times.
- Drive rx with 0x02, 0x3C -> leds=8'h3C with one leds_valid pulse; display_valid does not fire.
- Drive rx with 0x03, then 64 bytes i+1 -> a single display_valid pulse; display[7:0]=8'h01, display[511:504]=8'h40; display unchanged until the final byte.
- Display frame with byte 10 sent with stop bit 0 -> one frame_error pulse, display keeps its prior value. A following 0x02, 0x55 is then parsed correctly.
- Switches 0x00->0x11 during a frame, then ->0x22 before it ends -> frame carrying 0x00 completes, then exactly one frame carrying 0x22; no 0x11 frame is sent.
- With MIN_OS_HOST_TIMEOUT_EN: send 0x03 plus 5 bytes, then idle for 5 byte-times -> frame_error pulse, parser idle. A new 0x02, 0x07 updates leds.
